// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan block.
package mux_scan_pkg;

  localparam int unsigned DEF_BUS_WIDTH = 4;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_DIV_COUNT = 50000;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Wraparound prescaler: emits a one-cycle step strobe every DIV_COUNT running cycles.
module scan_prescaler
  import mux_scan_pkg::*;
#(
  parameter int unsigned DIV_COUNT = DEF_DIV_COUNT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic step
);

  localparam int unsigned CntW = (clog2(DIV_COUNT) < 1) ? 1 : clog2(DIV_COUNT);

  logic [CntW-1:0] r_cnt;
  logic            w_at_top;

  assign w_at_top = (r_cnt == CntW'(DIV_COUNT - 1));
  assign step     = w_at_top & run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_at_top ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_nx_nbit.sv
// N-channel scan selector: prescaled digit walk, manual override, blanking and
// registered data/anode outputs for a multi-digit seven-segment display.
module mux_scan_nx_nbit
  import mux_scan_pkg::*;
#(
  parameter int unsigned  BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int unsigned  NUM_CH    = DEF_NUM_CH,
  parameter int unsigned  DIV_COUNT = DEF_DIV_COUNT,
  localparam int unsigned SEL_WIDTH = clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        mode,
  input  logic [SEL_WIDTH-1:0]        sel_in,
  input  logic [NUM_CH*BUS_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]           blank_mask,
  output logic [BUS_WIDTH-1:0]        y,
  output logic [NUM_CH-1:0]           an_n,
  output logic [SEL_WIDTH-1:0]        sel,
  output logic                        frame_tick
);

  logic [SEL_WIDTH-1:0] r_sel;
  logic [BUS_WIDTH-1:0] r_y;
  logic [NUM_CH-1:0]    r_an_n;
  logic                 r_frame_tick;

  logic                 w_step;
  logic                 w_pre_reset;
  logic                 w_at_last;
  logic [SEL_WIDTH-1:0] w_sel_man;
  logic [BUS_WIDTH-1:0] w_y;
  logic                 w_blank;
  logic [NUM_CH-1:0]    w_an_n;

  // Manual mode pins the prescaler at zero so auto scan resumes with a full period.
  assign w_pre_reset = reset | mode;

  scan_prescaler #(
    .DIV_COUNT (DIV_COUNT)
  ) u_prescaler (
    .clk   (clk),
    .reset (w_pre_reset),
    .run   (en & ~mode),
    .step  (w_step)
  );

  assign w_at_last = (r_sel == SEL_WIDTH'(NUM_CH - 1));
  assign w_sel_man = ({1'b0, sel_in} >= (SEL_WIDTH + 1)'(NUM_CH)) ? '0 : sel_in;

  always_comb begin
    w_y     = '0;
    w_blank = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_sel == SEL_WIDTH'(k)) begin
        w_y     = data_in[k*BUS_WIDTH +: BUS_WIDTH];
        w_blank = blank_mask[k];
      end
    end
  end

  always_comb begin
    w_an_n = '1;
    if (!w_blank) begin
      w_an_n = ~(NUM_CH'(1) << r_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= '0;
      r_y          <= '0;
      r_an_n       <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_y          <= w_y;
      r_an_n       <= w_an_n;
      r_frame_tick <= w_step & w_at_last;
      if (mode) begin
        r_sel <= w_sel_man;
      end else if (w_step) begin
        r_sel <= w_at_last ? '0 : r_sel + SEL_WIDTH'(1);
      end
    end
  end

  assign y          = r_y;
  assign an_n       = r_an_n;
  assign sel        = r_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_mux_scan_nx_nbit.sv
// Drives a 4-channel/DIV=4 and a 3-channel/DIV=1 instance with shared stimulus and
// checks both against a cycle model through an expected-value queue.
module tb_mux_scan_nx_nbit;

  typedef struct {
    int         cnt;
    int         sel;
    logic [3:0] y;
    logic [3:0] an;
    logic       ft;
  } mst_t;

  typedef struct {
    mst_t a;
    mst_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        mode;
  logic [1:0]  sel_in;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;

  logic [3:0]  y4;
  logic [3:0]  an4;
  logic [1:0]  sel4;
  logic        ft4;
  logic [3:0]  y3;
  logic [2:0]  an3;
  logic [1:0]  sel3;
  logic        ft3;

  int   n_tests = 0;
  int   n_fail  = 0;
  mst_t m4;
  mst_t m3;
  exp_t q[$];

  always #5 clk = ~clk;

  mux_scan_nx_nbit #(
    .BUS_WIDTH (4),
    .NUM_CH    (4),
    .DIV_COUNT (4)
  ) dut4 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sel_in     (sel_in),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .y          (y4),
    .an_n       (an4),
    .sel        (sel4),
    .frame_tick (ft4)
  );

  mux_scan_nx_nbit #(
    .BUS_WIDTH (4),
    .NUM_CH    (3),
    .DIV_COUNT (1)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sel_in     (sel_in),
    .data_in    (data_in[11:0]),
    .blank_mask (blank_mask[2:0]),
    .y          (y3),
    .an_n       (an3),
    .sel        (sel3),
    .frame_tick (ft3)
  );

  function automatic mst_t model(input mst_t s, input int n, input int d);
    mst_t r;
    logic step;
    r = s;
    if (reset) begin
      r.cnt = 0;
      r.sel = 0;
      r.y   = 4'h0;
      r.an  = 4'hF;
      r.ft  = 1'b0;
      return r;
    end
    r.y = data_in[s.sel*4 +: 4];
    for (int i = 0; i < 4; i++) begin
      r.an[i] = (i >= n) || blank_mask[s.sel] || (i != s.sel);
    end
    step = (s.cnt == d - 1) && en && !mode;
    r.ft = step && (s.sel == n - 1);
    if (mode) begin
      r.cnt = 0;
      r.sel = (int'(sel_in) >= n) ? 0 : int'(sel_in);
    end else if (en) begin
      r.cnt = step ? 0 : s.cnt + 1;
      if (step) r.sel = (s.sel == n - 1) ? 0 : s.sel + 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push model expectations for this edge, advance one clock, pop and compare.
  task automatic tick();
    exp_t e;
    m4 = model(m4, 4, 4);
    m3 = model(m3, 3, 1);
    e.a = m4;
    e.b = m3;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sel4", {30'b0, sel4}, e.a.sel);
    chk("y4",   {28'b0, y4},   {28'b0, e.a.y});
    chk("an4",  {28'b0, an4},  {28'b0, e.a.an});
    chk("ft4",  {31'b0, ft4},  {31'b0, e.a.ft});
    chk("sel3", {30'b0, sel3}, e.b.sel);
    chk("y3",   {28'b0, y3},   {28'b0, e.b.y});
    chk("an3",  {29'b0, an3},  {29'b0, e.b.an[2:0]});
    chk("ft3",  {31'b0, ft3},  {31'b0, e.b.ft});
  endtask

  initial begin
    int ft_cnt;
    int ticks;
    logic [1:0] s0;

    reset      = 1'b1;
    en         = 1'b0;
    mode       = 1'b0;
    sel_in     = 2'd0;
    data_in    = 16'h4321;
    blank_mask = 4'b0000;
    m4 = '{cnt: 0, sel: 0, y: 4'h0, an: 4'hF, ft: 1'b0};
    m3 = m4;
    #1;

    // Reset
    tick();
    tick();
    chk("rst_y",    {28'b0, y4},   32'h0);
    chk("rst_an",   {28'b0, an4},  32'hF);
    chk("rst_sel",  {30'b0, sel4}, 32'h0);
    chk("rst_ft",   {31'b0, ft4},  32'h0);
    reset = 1'b0;
    en    = 1'b1;
    tick();
    chk("rel_y",  {28'b0, y4},  32'h1);
    chk("rel_an", {28'b0, an4}, 32'b1110);

    // Auto scan: exactly one frame wrap in one full 16-cycle frame
    ft_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ft4) ft_cnt++;
      chk("sel3_range", {31'b0, (sel3 < 2'd3)}, 32'h1);
    end
    chk("ft4_per_frame", ft_cnt, 32'd1);

    // Blanking channel 2
    blank_mask = 4'b0100;
    ticks = 0;
    while (sel4 != 2'd2 && ticks < 30) begin
      tick();
      ticks++;
    end
    chk("wait_sel2_timeout", {31'b0, (ticks < 30)}, 32'h1);
    tick();
    chk("blank_an", {28'b0, an4}, 32'b1111);
    chk("blank_y",  {28'b0, y4},  32'h3);
    blank_mask = 4'b0000;

    // Freeze at sel=1
    ticks = 0;
    while (sel4 != 2'd1 && ticks < 30) begin
      tick();
      ticks++;
    end
    chk("wait_sel1_timeout", {31'b0, (ticks < 30)}, 32'h1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_sel", {30'b0, sel4}, 32'h1);
    chk("hold_an",  {28'b0, an4},  32'b1101);
    data_in[7:4] = 4'h9;
    tick();
    chk("data_upd", {28'b0, y4}, 32'h9);

    // Manual mode
    en     = 1'b1;
    mode   = 1'b1;
    sel_in = 2'd2;
    tick();
    chk("man_sel", {30'b0, sel4}, 32'h2);
    chk("man_ft",  {31'b0, ft4},  32'h0);
    tick();
    chk("man_y", {28'b0, y4}, 32'h3);
    sel_in = 2'd3;
    tick();
    chk("man_clamp3", {30'b0, sel3}, 32'h0);
    chk("man_sel4_3", {30'b0, sel4}, 32'h3);
    tick();

    // Back to auto: first step after a full period
    mode  = 1'b0;
    s0    = sel4;
    ticks = 0;
    while (sel4 == s0 && ticks < 20) begin
      tick();
      ticks++;
    end
    chk("auto_resume_cycles", ticks, 32'd4);

    // Mid-scan reset at sel=2, count=2
    ticks = 0;
    while (!(m4.sel == 2 && m4.cnt == 2) && ticks < 40) begin
      tick();
      ticks++;
    end
    chk("wait_mid_timeout", {31'b0, (ticks < 40)}, 32'h1);
    chk("mid_sel_pre", {30'b0, sel4}, 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_sel", {30'b0, sel4}, 32'h0);
    chk("mid_rst_an",  {28'b0, an4},  32'hF);
    chk("mid_rst_y",   {28'b0, y4},   32'h0);
    reset = 1'b0;
    ticks = 0;
    while (sel4 == 2'd0 && ticks < 20) begin
      tick();
      ticks++;
    end
    chk("post_rst_step", ticks, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
